// File: rtl/spi_master_cfg_if.sv
// Host-side and serial-side signal bundle for spi_master_cfg.
// The master modport is the SPI master's view; the slave modport is the environment's view.
interface spi_master_cfg_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic              start;
    logic [WIDTH-1:0]  data_in;
    logic [CS_W-1:0]   cs_sel;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [DIV_W-1:0]  clk_div;
    logic              miso;
    logic              sclk;
    logic              mosi;
    logic [NUM_CS-1:0] cs_n;
    logic [WIDTH-1:0]  data_out;
    logic              busy;
    logic              done;
    logic              cfg_err;

    modport master (
        input  start, data_in, cs_sel, cpol, cpha, lsb_first, clk_div, miso,
        output sclk, mosi, cs_n, data_out, busy, done, cfg_err
    );

    modport slave (
        output start, data_in, cs_sel, cpol, cpha, lsb_first, clk_div, miso,
        input  sclk, mosi, cs_n, data_out, busy, done, cfg_err
    );
endinterface

// File: rtl/spi_master_cfg.sv
// Runtime-configurable SPI master: per-transfer mode, bit order, chip select and SCLK divider.
// Every output comes straight from a register; the FSM walks IDLE -> SETUP -> XFER -> HOLD.
module spi_master_cfg #(
    parameter int WIDTH  = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
) (
    input  logic clk,
    input  logic rst_n,
    spi_master_cfg_if.master bus
);
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int EDGE_W = $clog2(2 * WIDTH + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * WIDTH);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_tx;
    logic [WIDTH-1:0]   r_rx;
    logic [WIDTH-1:0]   r_data_out;
    logic [CS_W-1:0]    r_cs_sel;
    logic               r_cpol;
    logic               r_cpha;
    logic               r_lsb;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   r_cnt;
    logic [EDGE_W-1:0]  r_edge;
    logic               r_sclk;
    logic               r_mosi;
    logic [NUM_CS-1:0]  r_cs_n;
    logic               r_busy;
    logic               r_done;
    logic               r_cfg_err;

    logic [31:0]        w_sel_idx;
    logic               w_cs_ok;
    logic [NUM_CS-1:0]  w_cs_low;
    logic               w_div_end;
    logic [EDGE_W-1:0]  w_edge_nx;
    logic               w_sample;
    logic               w_shift;

    function automatic logic first_bit(input logic [WIDTH-1:0] x, input logic lsb);
        return lsb ? x[0] : x[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_tx(input logic [WIDTH-1:0] x, input logic lsb);
        return lsb ? {1'b0, x[WIDTH-1:1]} : {x[WIDTH-2:0], 1'b0};
    endfunction

    function automatic logic [WIDTH-1:0] insert_rx(input logic [WIDTH-1:0] x, input logic b,
                                                   input logic lsb);
        return lsb ? {b, x[WIDTH-1:1]} : {x[WIDTH-2:0], b};
    endfunction

    // In IDLE the select decodes from the live input; afterwards only the latched copy counts.
    assign w_sel_idx = 32'((r_state == IDLE) ? bus.cs_sel : r_cs_sel);
    assign w_cs_ok   = (32'(bus.cs_sel) < 32'(NUM_CS));

    always_comb begin
        w_cs_low = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (w_sel_idx == 32'(i)) w_cs_low[i] = 1'b0;
        end
    end

    assign w_div_end = (r_cnt == r_div);
    assign w_edge_nx = r_edge + EDGE_W'(1);
    // cpha=0 samples on odd (leading) edges; cpha=1 samples on even (trailing) edges.
    assign w_sample  = r_cpha ? ~w_edge_nx[0] : w_edge_nx[0];
    assign w_shift   = r_cpha ? w_edge_nx[0] : (~w_edge_nx[0] && (w_edge_nx != LAST_EDGE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tx       <= '0;
            r_rx       <= '0;
            r_data_out <= '0;
            r_cs_sel   <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_edge     <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= '1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sclk <= bus.cpol;
                    r_mosi <= 1'b0;
                    if (bus.start && w_cs_ok) begin
                        r_state  <= SETUP;
                        r_busy   <= 1'b1;
                        r_cs_n   <= w_cs_low;
                        r_cs_sel <= bus.cs_sel;
                        r_cpol   <= bus.cpol;
                        r_cpha   <= bus.cpha;
                        r_lsb    <= bus.lsb_first;
                        r_div    <= bus.clk_div;
                        r_cnt    <= '0;
                        r_edge   <= '0;
                        r_rx     <= '0;
                        // With cpha=0 the first bit must already be on mosi before edge 1.
                        r_mosi   <= bus.cpha ? 1'b0 : first_bit(bus.data_in, bus.lsb_first);
                        r_tx     <= bus.cpha ? bus.data_in : shift_tx(bus.data_in, bus.lsb_first);
                    end else if (bus.start) begin
                        r_cfg_err <= 1'b1;
                    end
                end
                SETUP, XFER: begin
                    r_cs_n <= w_cs_low;
                    if (w_div_end) begin
                        r_cnt <= '0;
                        if (r_state == XFER && r_edge == LAST_EDGE) begin
                            r_state <= HOLD;
                        end else begin
                            r_state <= XFER;
                            r_edge  <= w_edge_nx;
                            r_sclk  <= ~r_sclk;
                            if (w_sample) r_rx <= insert_rx(r_rx, bus.miso, r_lsb);
                            if (w_shift) begin
                                r_mosi <= first_bit(r_tx, r_lsb);
                                r_tx   <= shift_tx(r_tx, r_lsb);
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (w_div_end) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_cs_n     <= '1;
                        r_done     <= 1'b1;
                        r_data_out <= r_rx;
                        r_sclk     <= r_cpol;
                        r_mosi     <= 1'b0;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.sclk     = r_sclk;
    assign bus.mosi     = r_mosi;
    assign bus.cs_n     = r_cs_n;
    assign bus.data_out = r_data_out;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.cfg_err  = r_cfg_err;
endmodule

// File: tb/tb_spi_master_cfg.sv
// Scoreboard bench for spi_master_cfg with a behavioural SPI slave on the serial pins.
// NUM_CS=5 makes cs_sel 3 bits wide so that index 5 is representable and out of range.
module tb_spi_master_cfg;
    localparam int W   = 8;
    localparam int NCS = 5;
    localparam int DW  = 8;

    typedef struct {
        bit               is_cfg;
        logic [W-1:0]     data;
        logic [W-1:0]     rx;
        int               busy;
        logic [NCS-1:0]   csm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_cfg_if #(.WIDTH(W), .NUM_CS(NCS), .DIV_W(DW)) bus ();
    spi_master_cfg #(.WIDTH(W), .NUM_CS(NCS), .DIV_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    exp_t q[$];
    int done_t[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Slave model: behaves per s_cpol/s_cpha/s_lsb, shifting s_tx out on miso, capturing mosi.
    logic          s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
    logic [W-1:0]  s_tx = '0, s_rx = '0;
    int            s_ti = 0, s_ri = 0;
    logic          sel_n;
    logic          s_prev_sel_n = 1'b1, s_prev_sclk = 1'b0;
    assign sel_n = &bus.cs_n;

    function automatic int pos(input int i, input logic lsb);
        return lsb ? i : (W - 1 - i);
    endfunction

    always @(bus.sclk or sel_n) begin
        if (!sel_n && s_prev_sel_n) begin
            s_ti = 0; s_ri = 0; s_rx = '0;
            if (!s_cpha) begin
                bus.miso = s_tx[pos(0, s_lsb)];
                s_ti = 1;
            end
        end else if (!sel_n && bus.sclk !== s_prev_sclk) begin
            if ((bus.sclk !== s_cpol) ^ s_cpha) begin
                if (s_ri < W) begin
                    s_rx[pos(s_ri, s_lsb)] = bus.mosi;
                    s_ri++;
                end
            end else if (s_ti < W) begin
                bus.miso = s_tx[pos(s_ti, s_lsb)];
                s_ti++;
            end
        end
        s_prev_sel_n = sel_n;
        s_prev_sclk  = bus.sclk;
    end

    int edges = 0, all_edges = 0, busy_cnt = 0;
    logic [NCS-1:0] cs_seen = '0;

    always @(bus.sclk) begin
        if (rst_n) begin
            all_edges++;
            if (!sel_n) edges++;
        end
    end

    // Monitor: every done or cfg_err pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0; edges = 0; cs_seen = '0;
        end else begin
            if (bus.busy) busy_cnt++;
            cs_seen = cs_seen | ~bus.cs_n;
            if (bus.done || bus.cfg_err) begin
                if (bus.done) done_t.push_back(cyc);
                if (q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_pulse: got done=%0b cfg_err=%0b expected none",
                             bus.done, bus.cfg_err);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind", 64'(bus.cfg_err), 64'(e.is_cfg));
                    if (e.is_cfg) begin
                        chk("cfg_busy", 64'(bus.busy), 64'(0));
                        chk("cfg_busy_cycles", 64'(busy_cnt), 64'(0));
                        chk("cfg_cs_lines", 64'(cs_seen), 64'(0));
                    end else begin
                        chk("data_out", 64'(bus.data_out), 64'(e.data));
                        chk("slave_rx", 64'(s_rx), 64'(e.rx));
                        chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
                        chk("sclk_edges", 64'(edges), 64'(2 * W));
                        chk("cs_lines", 64'(cs_seen), 64'(e.csm));
                        chk("done_cs_high", 64'(bus.cs_n), 64'({NCS{1'b1}}));
                    end
                end
                busy_cnt = 0; edges = 0; cs_seen = '0;
            end
        end
    end

    task automatic issue(input logic cpol, input logic cpha, input logic lsb, input logic [2:0] cs,
                         input logic [DW-1:0] div, input logic [W-1:0] data,
                         input logic [W-1:0] stx, input bit push);
        exp_t e;
        bus.cpol = cpol; bus.cpha = cpha; bus.lsb_first = lsb;
        bus.cs_sel = cs; bus.clk_div = div; bus.data_in = data;
        s_cpol = cpol; s_cpha = cpha; s_lsb = lsb; s_tx = stx;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_sclk", 64'(bus.sclk), 64'(cpol));
        chk("idle_mosi", 64'(bus.mosi), 64'(0));
        e.is_cfg = (cs >= 3'(NCS));
        e.data = stx; e.rx = data;
        e.busy = (2 * W + 2) * (int'(div) + 1);
        e.csm  = NCS'(1) << cs;
        if (push) q.push_back(e);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((q.size() != 0 || bus.busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, q.size());
        end
    endtask

    initial begin
        exp_t e;
        int n, e0;
        bus.start = 1'b0; bus.data_in = '0; bus.cs_sel = '0; bus.cpol = 1'b0;
        bus.cpha = 1'b0; bus.lsb_first = 1'b0; bus.clk_div = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", 64'(bus.sclk), 64'(0));
        chk("rst_mosi", 64'(bus.mosi), 64'(0));
        chk("rst_cs_n", 64'(bus.cs_n), 64'({NCS{1'b1}}));
        chk("rst_data_out", 64'(bus.data_out), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_cfg_err", 64'(bus.cfg_err), 64'(0));
        rst_n = 1'b1;

        // Mode 0, H=2, MSB first on cs 0: 36 busy cycles.
        issue(1'b0, 1'b0, 1'b0, 3'd0, 8'd1, 8'hA5, 8'h3C, 1'b1);
        wait_idle("mode0", 200);

        // Mode 3, LSB first on cs 2; sclk idles high on both sides.
        issue(1'b1, 1'b1, 1'b1, 3'd2, 8'd1, 8'h5A, 8'hC3, 1'b1);
        wait_idle("mode3", 200);
        chk("mode3_idle_after", 64'(bus.sclk), 64'(1));

        // Out-of-range chip select is rejected without touching the bus.
        e0 = all_edges;
        issue(1'b1, 1'b1, 1'b1, 3'd5, 8'd1, 8'h11, 8'h22, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("cfg_no_sclk", 64'(all_edges - e0), 64'(0));
        chk("cfg_cs_n", 64'(bus.cs_n), 64'({NCS{1'b1}}));
        wait_idle("cfg", 20);

        // Mode 1, H=3; a second start mid-transfer must be ignored.
        issue(1'b0, 1'b1, 1'b0, 3'd1, 8'd2, 8'h96, 8'h4D, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        bus.data_in = 8'hFF; bus.cs_sel = 3'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle("midstart", 400);
        repeat (60) @(posedge clk);

        // Mode 2, H=1, back-to-back: second start issued in the done cycle.
        issue(1'b1, 1'b0, 1'b0, 3'd4, 8'd0, 8'h81, 8'h7E, 1'b1);
        n = 0;
        while (!bus.done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_first_done", 64'(bus.done), 64'(1));
        bus.data_in = 8'h3C; s_tx = 8'hE7;
        e.is_cfg = 1'b0; e.data = 8'hE7; e.rx = 8'h3C; e.busy = 2 * W + 2; e.csm = NCS'(1) << 4;
        q.push_back(e);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle("b2b", 100);
        // Start is sampled one edge after done appears, so pulses land 2*W+2+1 edges apart.
        if (done_t.size() >= 2)
            chk("b2b_spacing", 64'(done_t[done_t.size()-1] - done_t[done_t.size()-2]),
                64'(2 * W + 3));
        else
            chk("b2b_done_count", 64'(done_t.size()), 64'(2));

        // Largest divider: H=256.
        issue(1'b0, 1'b0, 1'b0, 3'd3, 8'hFF, 8'hC3, 8'h18, 1'b1);
        wait_idle("maxdiv", 6000);

        // Reset in the middle of XFER aborts without done and clears data_out.
        chk("pre_reset_data_out", 64'(bus.data_out), 64'(8'h18));
        issue(1'b0, 1'b0, 1'b0, 3'd0, 8'd1, 8'h77, 8'h11, 1'b0);
        repeat (12) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", 64'(bus.cs_n), 64'({NCS{1'b1}}));
        chk("abort_sclk", 64'(bus.sclk), 64'(0));
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_data_out", 64'(bus.data_out), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_data_hold", 64'(bus.data_out), 64'(0));

        // Recovery after reset: mode 0, H=1, LSB first on cs 1.
        issue(1'b0, 1'b0, 1'b1, 3'd1, 8'd0, 8'h01, 8'h80, 1'b1);
        wait_idle("recover", 100);
        repeat (5) @(posedge clk);

        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
